// File: rtl/add_round_key_stream.sv
// add_round_key_stream: byte-stream AddRoundKey stage with a run-time writable
// round-key store. Processes LANES state bytes per beat, tracks the beat
// position inside each 16-byte block, and registers the XOR result with one
// cycle of latency behind a valid/ready handshake on both sides.
module add_round_key_stream #(
   parameter int LANES = 1,
   parameter int NR    = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_wr_en,
   input  logic [3:0]         key_wr_round,
   input  logic [3:0]         key_wr_byte,
   input  logic [7:0]         key_wr_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   input  logic [3:0]         in_round,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic               out_last,
   output logic [3:0]         out_round,
   output logic               err
);

   localparam int         BEATS     = 16 / LANES;
   localparam logic [3:0] LAST_BIDX = 4'(BEATS - 1);

   // Round keys live in flops so any round can be read in the same cycle.
   logic [7:0]         key_mem [0:NR][0:15];
   logic [NR:0]        loaded;

   logic [3:0]         bidx;
   logic [3:0]         cur_round;
   logic               accept;
   logic               first_beat;
   logic               last_beat;
   logic [3:0]         sel_round;
   logic               key_ok;
   logic [7:0]         key_block [0:15];
   logic [8*LANES-1:0] key_lanes;
   logic [8*LANES-1:0] next_data;

   // Single output register: room exists when it is empty or being drained.
   assign in_ready   = !out_valid || out_ready;
   assign accept     = in_valid && in_ready;
   assign first_beat = (bidx == 4'd0);
   assign last_beat  = (bidx == LAST_BIDX);
   assign sel_round  = first_beat ? in_round : cur_round;
   assign next_data  = in_data ^ key_lanes;

   // Store one key byte per cycle; rounds beyond NR have no storage and are dropped.
   always_ff @(posedge clk) begin
      for (int r = 0; r <= NR; r++) begin
         if (key_wr_en && (key_wr_round == 4'(r))) begin
            key_mem[r][key_wr_byte] <= key_wr_data;
         end
      end
   end

   // A round counts as loaded once its final byte (index 15) has been written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loaded <= '0;
      end else begin
         for (int r = 0; r <= NR; r++) begin
            if (key_wr_en && (key_wr_round == 4'(r)) && (key_wr_byte == 4'd15)) begin
               loaded[r] <= 1'b1;
            end
         end
      end
   end

   // Pick the selected round key; out-of-range or unloaded rounds yield an all-zero key.
   always_comb begin
      key_ok = 1'b0;
      for (int b = 0; b < 16; b++) begin
         key_block[b] = 8'h00;
      end
      for (int r = 0; r <= NR; r++) begin
         if ((sel_round == 4'(r)) && loaded[r]) begin
            key_ok = 1'b1;
            for (int b = 0; b < 16; b++) begin
               key_block[b] = key_mem[r][b];
            end
         end
      end
   end

   // Map the key bytes for this beat onto lanes, lowest byte index in the top lane.
   always_comb begin
      key_lanes = '0;
      for (int k = 0; k < LANES; k++) begin
         key_lanes[8*LANES-1-8*k -: 8] = key_block[4'(int'(bidx) * LANES + k)];
      end
   end

   // Track beat position within the block and latch the round on the first beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bidx      <= 4'd0;
         cur_round <= 4'd0;
      end else if (accept) begin
         bidx <= last_beat ? 4'd0 : bidx + 4'd1;
         if (first_beat) begin
            cur_round <= in_round;
         end
      end
   end

   // Output register: load on acceptance, empty when drained with nothing new arriving.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_round <= 4'd0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= next_data;
         out_last  <= last_beat;
         out_round <= sel_round;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky error whenever an accepted beat had no usable key.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (accept && !key_ok) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_add_round_key_stream.sv
// tb_add_round_key_stream: directed, table-driven checks of the AddRoundKey
// stream stage with one LANES=1 and one LANES=4 instance sharing clock, reset
// and the key-write bus.
module tb_add_round_key_stream;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  round;
      logic [31:0] exp_data;
      logic        exp_last;
      logic [3:0]  exp_round;
      logic        exp_err;
   } vec_t;

   localparam logic [127:0] KEY0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY3   = 128'h11111111111111111111111111111111;
   localparam logic [127:0] PT     = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] BP_IN  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] BP_EXP = 128'hd005db9b8dbb43fe69a6a6737abee259;
   localparam logic [127:0] ERR_IN = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_wr_en;
   logic [3:0]  key_wr_round;
   logic [3:0]  key_wr_byte;
   logic [7:0]  key_wr_data;

   logic        l1_in_valid, l1_in_ready, l1_out_valid, l1_out_ready, l1_out_last, l1_err;
   logic [7:0]  l1_in_data, l1_out_data;
   logic [3:0]  l1_in_round, l1_out_round;

   logic        l4_in_valid, l4_in_ready, l4_out_valid, l4_out_ready, l4_out_last, l4_err;
   logic [31:0] l4_in_data, l4_out_data;
   logic [3:0]  l4_in_round, l4_out_round;

   int          checks = 0;
   int          passed = 0;
   vec_t        vecs [16];
   logic [127:0] key_copy;

   add_round_key_stream #(.LANES(1), .NR(10)) u_l1 (
      .clk(clk), .rst(rst),
      .key_wr_en(key_wr_en), .key_wr_round(key_wr_round),
      .key_wr_byte(key_wr_byte), .key_wr_data(key_wr_data),
      .in_valid(l1_in_valid), .in_ready(l1_in_ready),
      .in_data(l1_in_data), .in_round(l1_in_round),
      .out_valid(l1_out_valid), .out_ready(l1_out_ready),
      .out_data(l1_out_data), .out_last(l1_out_last),
      .out_round(l1_out_round), .err(l1_err)
   );

   add_round_key_stream #(.LANES(4), .NR(10)) u_l4 (
      .clk(clk), .rst(rst),
      .key_wr_en(key_wr_en), .key_wr_round(key_wr_round),
      .key_wr_byte(key_wr_byte), .key_wr_data(key_wr_data),
      .in_valid(l4_in_valid), .in_ready(l4_in_ready),
      .in_data(l4_in_data), .in_round(l4_in_round),
      .out_valid(l4_out_valid), .out_ready(l4_out_ready),
      .out_data(l4_out_data), .out_last(l4_out_last),
      .out_round(l4_out_round), .err(l4_err)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end else begin
         passed++;
      end
   endtask

   task automatic applyStimulus(input int lanes, input logic [31:0] data,
                                input logic [3:0] round);
      if (lanes == 1) begin
         l1_in_valid = 1'b1;
         l1_in_data  = data[7:0];
         l1_in_round = round;
      end else begin
         l4_in_valid = 1'b1;
         l4_in_data  = data;
         l4_in_round = round;
      end
   endtask

   task automatic idle();
      l1_in_valid = 1'b0;
      l4_in_valid = 1'b0;
   endtask

   task automatic writeKey(input logic [3:0] round, input logic [127:0] key);
      for (int b = 0; b < 16; b++) begin
         key_wr_en    = 1'b1;
         key_wr_round = round;
         key_wr_byte  = 4'(b);
         key_wr_data  = key[127-8*b -: 8];
         tick();
      end
      key_wr_en = 1'b0;
   endtask

   task automatic checkBeat(input int lanes, input string tag, input vec_t v);
      if (lanes == 1) begin
         checkOutput({tag, " valid"}, {31'd0, l1_out_valid}, 32'd1);
         checkOutput({tag, " data"},  {24'd0, l1_out_data}, v.exp_data);
         checkOutput({tag, " last"},  {31'd0, l1_out_last}, {31'd0, v.exp_last});
         checkOutput({tag, " round"}, {28'd0, l1_out_round}, {28'd0, v.exp_round});
         checkOutput({tag, " err"},   {31'd0, l1_err}, {31'd0, v.exp_err});
      end else begin
         checkOutput({tag, " valid"}, {31'd0, l4_out_valid}, 32'd1);
         checkOutput({tag, " data"},  l4_out_data, v.exp_data);
         checkOutput({tag, " last"},  {31'd0, l4_out_last}, {31'd0, v.exp_last});
         checkOutput({tag, " round"}, {28'd0, l4_out_round}, {28'd0, v.exp_round});
         checkOutput({tag, " err"},   {31'd0, l4_err}, {31'd0, v.exp_err});
      end
   endtask

   task automatic fillBytes(input logic [127:0] din, input logic [127:0] dexp,
                            input logic [3:0] r0, input logic [3:0] rlater,
                            input logic [3:0] eround, input logic eerr);
      for (int i = 0; i < 16; i++) begin
         vecs[i].data      = {24'd0, din[127-8*i -: 8]};
         vecs[i].round     = (i == 0) ? r0 : rlater;
         vecs[i].exp_data  = {24'd0, dexp[127-8*i -: 8]};
         vecs[i].exp_last  = (i == 15);
         vecs[i].exp_round = eround;
         vecs[i].exp_err   = eerr;
      end
   endtask

   task automatic fillWords(input logic [127:0] din, input logic [127:0] dexp,
                            input logic [3:0] r0, input logic [3:0] rlater,
                            input logic [3:0] eround, input logic eerr);
      for (int i = 0; i < 4; i++) begin
         vecs[i].data      = din[127-32*i -: 32];
         vecs[i].round     = (i == 0) ? r0 : rlater;
         vecs[i].exp_data  = dexp[127-32*i -: 32];
         vecs[i].exp_last  = (i == 3);
         vecs[i].exp_round = eround;
         vecs[i].exp_err   = eerr;
      end
   endtask

   task automatic runVectors(input int lanes, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         applyStimulus(lanes, vecs[i].data, vecs[i].round);
         tick();
         checkBeat(lanes, $sformatf("%s[%0d]", tag, i), vecs[i]);
      end
      idle();
      tick();
      if (lanes == 1) begin
         checkOutput({tag, " drained"}, {31'd0, l1_out_valid}, 32'd0);
      end else begin
         checkOutput({tag, " drained"}, {31'd0, l4_out_valid}, 32'd0);
      end
   endtask

   // Directed test sequence.
   initial begin
      rst          = 1'b1;
      key_wr_en    = 1'b0;
      key_wr_round = 4'd0;
      key_wr_byte  = 4'd0;
      key_wr_data  = 8'd0;
      l1_in_data   = 8'd0;
      l1_in_round  = 4'd0;
      l4_in_data   = 32'd0;
      l4_in_round  = 4'd0;
      l1_out_ready = 1'b1;
      l4_out_ready = 1'b1;
      idle();

      #3;
      checkOutput("rst l1 in_ready",  {31'd0, l1_in_ready}, 32'd1);
      checkOutput("rst l1 out_valid", {31'd0, l1_out_valid}, 32'd0);
      checkOutput("rst l1 out_data",  {24'd0, l1_out_data}, 32'd0);
      checkOutput("rst l1 out_last",  {31'd0, l1_out_last}, 32'd0);
      checkOutput("rst l1 out_round", {28'd0, l1_out_round}, 32'd0);
      checkOutput("rst l1 err",       {31'd0, l1_err}, 32'd0);
      checkOutput("rst l4 in_ready",  {31'd0, l4_in_ready}, 32'd1);
      checkOutput("rst l4 out_valid", {31'd0, l4_out_valid}, 32'd0);
      checkOutput("rst l4 out_data",  l4_out_data, 32'd0);
      checkOutput("rst l4 out_last",  {31'd0, l4_out_last}, 32'd0);
      checkOutput("rst l4 out_round", {28'd0, l4_out_round}, 32'd0);
      checkOutput("rst l4 err",       {31'd0, l4_err}, 32'd0);

      tick();
      rst = 1'b0;
      tick();
      writeKey(4'd0, KEY0);
      writeKey(4'd10, KEY10);
      writeKey(4'd3, KEY3);

      $display("[TB] FIPS-197 round 0, one byte per beat");
      fillBytes(PT, CT, 4'd0, 4'd3, 4'd0, 1'b0);
      runVectors(1, 16, "fips");

      $display("[TB] round 10 select, four bytes per beat");
      fillWords(128'd0, KEY10, 4'd10, 4'd3, 4'd10, 1'b0);
      runVectors(4, 4, "rk10");

      $display("[TB] backpressure mid-block");
      fillWords(BP_IN, BP_EXP, 4'd10, 4'd3, 4'd10, 1'b0);
      applyStimulus(4, vecs[0].data, vecs[0].round);
      tick();
      checkBeat(4, "bp[0]", vecs[0]);
      applyStimulus(4, vecs[1].data, vecs[1].round);
      tick();
      checkBeat(4, "bp[1]", vecs[1]);
      applyStimulus(4, vecs[2].data, vecs[2].round);
      l4_out_ready = 1'b0;
      #1;
      checkOutput("bp stall in_ready", {31'd0, l4_in_ready}, 32'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         checkBeat(4, $sformatf("bp hold%0d", c), vecs[1]);
         checkOutput($sformatf("bp hold%0d in_ready", c), {31'd0, l4_in_ready}, 32'd0);
      end
      l4_out_ready = 1'b1;
      #1;
      checkOutput("bp release in_ready", {31'd0, l4_in_ready}, 32'd1);
      tick();
      checkBeat(4, "bp[2]", vecs[2]);
      applyStimulus(4, vecs[3].data, vecs[3].round);
      tick();
      checkBeat(4, "bp[3]", vecs[3]);
      idle();
      tick();
      checkOutput("bp drained", {31'd0, l4_out_valid}, 32'd0);

      $display("[TB] error path: round above NR and unloaded round");
      fillBytes(BP_IN, BP_IN, 4'd11, 4'd11, 4'd11, 1'b1);
      runVectors(1, 16, "err11");
      fillWords(ERR_IN, ERR_IN, 4'd5, 4'd5, 4'd5, 1'b1);
      runVectors(4, 4, "unl5");
      checkOutput("err sticky l1", {31'd0, l1_err}, 32'd1);

      rst = 1'b1;
      #1;
      checkOutput("rst clears l1 err", {31'd0, l1_err}, 32'd0);
      checkOutput("rst clears l4 err", {31'd0, l4_err}, 32'd0);
      checkOutput("rst l1 out_valid",  {31'd0, l1_out_valid}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] loaded flags cleared by reset");
      fillWords(128'd0, 128'd0, 4'd10, 4'd10, 4'd10, 1'b1);
      runVectors(4, 4, "noload");
      writeKey(4'd0, KEY0);
      writeKey(4'd10, KEY10);

      $display("[TB] key write / stream read collision");
      key_copy     = KEY0;
      key_wr_en    = 1'b1;
      key_wr_round = 4'd0;
      key_wr_byte  = 4'd0;
      key_wr_data  = 8'hff;
      applyStimulus(1, 32'd0, 4'd0);
      tick();
      key_wr_en = 1'b0;
      checkOutput("coll old byte",  {24'd0, l1_out_data}, 32'h2b);
      checkOutput("coll round",     {28'd0, l1_out_round}, 32'd0);
      for (int i = 1; i < 16; i++) begin
         applyStimulus(1, 32'd0, 4'd3);
         tick();
         checkOutput($sformatf("coll byte%0d", i), {24'd0, l1_out_data},
                     {24'd0, key_copy[127-8*i -: 8]});
         checkOutput($sformatf("coll last%0d", i), {31'd0, l1_out_last},
                     (i == 15) ? 32'd1 : 32'd0);
      end
      applyStimulus(1, 32'd0, 4'd0);
      tick();
      checkOutput("coll new byte", {24'd0, l1_out_data}, 32'hff);
      for (int i = 1; i < 7; i++) begin
         applyStimulus(1, 32'd0, 4'd0);
         tick();
         checkOutput($sformatf("pre-rst byte%0d", i), {24'd0, l1_out_data},
                     {24'd0, key_copy[127-8*i -: 8]});
      end

      $display("[TB] reset after 7 of 16 bytes");
      idle();
      rst = 1'b1;
      #1;
      checkOutput("mid rst drops beat", {31'd0, l1_out_valid}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      writeKey(4'd0, KEY0);
      writeKey(4'd10, KEY10);
      fillBytes(128'd0, KEY10, 4'd10, 4'd3, 4'd10, 1'b0);
      runVectors(1, 16, "restart");

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
